instruction_sequencer_verilog: RTL and testbench

Fetch/decode/issue sequencer directly upstream of the ALU/register stage. Reads 32-bit instruction words from a synchronous program memory and splits each into the 16-bit `opcode` and `operand` buses that drive the ALU/register stage. Resolves control instructions (halt, jump, flag branch) locally using the ALU/register stage's `alu_flags`. Owns the program counter and a retired-instruction counter.

---
 rtl/instruction_sequencer_verilog_if.sv | 25 ++
 rtl/instruction_sequencer_verilog.sv | 77 +++++++
 tb/tb_instruction_sequencer_verilog.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_verilog_if.sv
// instruction_sequencer_verilog_if: program-memory, flag and issue bus between sequencer and its environment
interface instruction_sequencer_verilog_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
);
   logic                    start;
   logic                    mem_rd_en;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [2*DATA_WIDTH-1:0] mem_rdata;
   logic [3:0]              alu_flags;
   logic [DATA_WIDTH-1:0]   opcode;
   logic [DATA_WIDTH-1:0]   operand;
   logic [ADDR_WIDTH-1:0]   pc;
   logic                    busy;
   logic                    halted;
   logic [15:0]             retired;
   modport master (
      output start, mem_rdata, alu_flags,
      input  mem_rd_en, mem_addr, opcode, operand, pc, busy, halted, retired
   );
   modport slave (
      input  start, mem_rdata, alu_flags,
      output mem_rd_en, mem_addr, opcode, operand, pc, busy, halted, retired
   );
endinterface

// File: rtl/instruction_sequencer_verilog.sv
// instruction_sequencer_verilog: fetch/decode/execute sequencer issuing opcode/operand pairs and resolving control flow locally
module instruction_sequencer_verilog #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] NOP_OPCODE = 16'hE000
) (
   input logic                           clk,
   input logic                           reset,
   instruction_sequencer_verilog_if.slave bus
);
   localparam int IW = 2*DATA_WIDTH;
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, HALTED} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d, mem_addr_q;
   logic [IW-1:0]         ir_q, ir_d;
   logic [15:0]           retired_q, retired_d;
   logic [DATA_WIDTH-1:0] opcode_q, operand_q;
   logic                  mem_rd_en_q, is_halt, br_take, issue_d;
   always_comb begin
      is_halt   = ir_q[IW-1 -: DATA_WIDTH] == {4'hF, {(DATA_WIDTH-4){1'b0}}};
      br_take   = ir_q[IW-1 -: 8] == 8'hF1 ||
                  (ir_q[IW-1 -: 8] == 8'hF2 && |(bus.alu_flags & ir_q[DATA_WIDTH +: 4]));
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      case (state_q)
         IDLE, HALTED: if (bus.start) begin
            state_d   = FETCH;
            pc_d      = '0;
            retired_d = '0;
         end
         FETCH: state_d = DECODE;
         DECODE: begin
            ir_d    = bus.mem_rdata;
            state_d = EXECUTE;
         end
         EXECUTE: begin
            state_d   = is_halt ? HALTED : FETCH;
            pc_d      = is_halt ? pc_q : br_take ? ir_q[ADDR_WIDTH-1:0] : pc_q + 1'b1;
            retired_d = &retired_q ? retired_q : retired_q + 16'd1;
         end
         default: state_d = IDLE;
      endcase
      // outputs are registered, so issue is decided from the instruction entering EXECUTE
      issue_d = state_d == EXECUTE && ir_d[IW-1 -: 4] != 4'hF;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         ir_q        <= '0;
         retired_q   <= '0;
         opcode_q    <= NOP_OPCODE;
         operand_q   <= '0;
         mem_rd_en_q <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         retired_q   <= retired_d;
         opcode_q    <= issue_d ? ir_d[IW-1 -: DATA_WIDTH] : NOP_OPCODE;
         operand_q   <= issue_d ? ir_d[DATA_WIDTH-1:0] : '0;
         mem_rd_en_q <= state_d == FETCH;
         mem_addr_q  <= state_d == FETCH ? pc_d : mem_addr_q;
      end
   end
   assign bus.mem_rd_en = mem_rd_en_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.opcode    = opcode_q;
   assign bus.operand   = operand_q;
   assign bus.pc        = pc_q;
   assign bus.retired   = retired_q;
   assign bus.busy      = state_q inside {FETCH, DECODE, EXECUTE};
   assign bus.halted    = state_q == HALTED;
endmodule

// File: tb/tb_instruction_sequencer_verilog.sv
// tb_instruction_sequencer_verilog: directed and random programs checked against an instruction-level reference model
module tb_instruction_sequencer_verilog;
   localparam int          DW  = 16;
   localparam int          AW  = 8;
   localparam logic [15:0] NOP = 16'hE000;
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   mem [256];
   int            n_tests = 0;
   int            n_fail = 0;
   logic [AW-1:0] m_pc;
   logic [15:0]   m_ret;
   bit            hit;
   instruction_sequencer_verilog_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   instruction_sequencer_verilog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NOP_OPCODE(NOP)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk_reset_vals(input string tag);
      chk({tag, "_opcode"}, bus.opcode, NOP);
      chk({tag, "_operand"}, bus.operand, 0);
      chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
      chk({tag, "_addr"}, bus.mem_addr, 0);
      chk({tag, "_pc"}, bus.pc, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_halted"}, bus.halted, 0);
      chk({tag, "_retired"}, bus.retired, 0);
   endtask
   task automatic fill_halt;
      for (int i = 0; i < 256; i++) mem[i] = 32'hF000_0000;
   endtask
   function automatic logic [31:0] gen_word();
      int          r = $urandom_range(0, 9);
      logic [31:0] x = $urandom;
      case (r)
         0:       return {16'hF000, x[15:0]};
         1:       return {8'hF1, x[23:0]};
         2, 3:    return {8'hF2, x[23:0]};
         4:       return {4'hF, 4'($urandom_range(3, 15)), x[23:0]};
         5:       return {8'hF0, 8'($urandom_range(1, 255)), x[15:0]};
         default: return {4'($urandom_range(0, 14)), x[27:0]};
      endcase
   endfunction
   // Executes one instruction per loop pass from the program image; start is pulsed randomly while busy
   task automatic run_prog(input int max_ins, input bit rnd_fl, input logic [3:0] fl, output bit hit_halt);
      logic [31:0]   w;
      logic [3:0]    f;
      logic [AW-1:0] nxt;
      bit            issued;
      hit_halt  = 1'b0;
      bus.start = 1'b1;
      tick;
      m_pc  = '0;
      m_ret = '0;
      for (int i = 0; i < max_ins; i++) begin
         bus.start = 1'($urandom_range(0, 1));
         chk("fetch_rd_en", bus.mem_rd_en, 1);
         chk("fetch_addr", bus.mem_addr, m_pc);
         chk("fetch_pc", bus.pc, m_pc);
         chk("fetch_busy", bus.busy, 1);
         chk("fetch_opcode", bus.opcode, NOP);
         chk("fetch_retired", bus.retired, m_ret);
         w = mem[m_pc];
         f = rnd_fl ? 4'($urandom) : fl;
         bus.alu_flags = f;
         tick;
         bus.start = 1'($urandom_range(0, 1));
         chk("decode_rd_en", bus.mem_rd_en, 0);
         chk("decode_opcode", bus.opcode, NOP);
         chk("decode_operand", bus.operand, 0);
         tick;
         bus.start = 1'($urandom_range(0, 1));
         issued = w[31:28] != 4'hF;
         chk("exec_opcode", bus.opcode, issued ? w[31:16] : NOP);
         chk("exec_operand", bus.operand, issued ? w[15:0] : 16'h0);
         chk("exec_rd_en", bus.mem_rd_en, 0);
         chk("exec_busy", bus.busy, 1);
         chk("exec_retired", bus.retired, m_ret);
         nxt = m_pc + 1'b1;
         if (w[31:24] == 8'hF1 || (w[31:24] == 8'hF2 && (f & w[19:16]) != 4'h0)) nxt = w[AW-1:0];
         m_ret = (m_ret == 16'hFFFF) ? m_ret : m_ret + 16'd1;
         if (w[31:16] == 16'hF000) begin
            bus.start = 1'b0;
            tick;
            chk("halt_halted", bus.halted, 1);
            chk("halt_busy", bus.busy, 0);
            chk("halt_pc", bus.pc, m_pc);
            chk("halt_retired", bus.retired, m_ret);
            chk("halt_opcode", bus.opcode, NOP);
            hit_halt = 1'b1;
            return;
         end
         m_pc = nxt;
         tick;
      end
      bus.start = 1'b0;
   endtask
   task automatic async_reset(input string tag);
      reset = 1'b0;
      #1;
      chk_reset_vals(tag);
      tick;
      reset = 1'b1;
   endtask
   initial begin
      bus.start     = 1'b0;
      bus.alu_flags = 4'h0;
      fill_halt();
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      reset = 1'b1;
      tick;
      mem[0] = 32'h0003_00AA;
      mem[1] = 32'hF000_0000;
      run_prog(5, 1'b1, 4'h0, hit);
      chk("basic_halt", hit, 1);
      chk("basic_retired", bus.retired, 2);
      chk("basic_pc", bus.pc, 1);
      repeat (3) begin
         tick;
         chk("halted_hold", bus.halted, 1);
         chk("halted_opcode", bus.opcode, NOP);
      end
      fill_halt();
      mem[0] = 32'hF100_0005;
      mem[5] = 32'h1002_0304;
      run_prog(5, 1'b1, 4'h0, hit);
      chk("jump_halt", hit, 1);
      chk("jump_pc", bus.pc, 6);
      chk("jump_retired", bus.retired, 3);
      fill_halt();
      mem[0] = 32'hF201_0010;
      run_prog(3, 1'b0, 4'b0001, hit);
      chk("br_taken_pc", bus.pc, 8'h10);
      run_prog(3, 1'b0, 4'b0010, hit);
      chk("br_not_taken_pc", bus.pc, 8'h01);
      fill_halt();
      mem[0]   = 32'hF100_00FF;
      mem[255] = 32'h0001_0002;
      run_prog(4, 1'b1, 4'h0, hit);
      chk("wrap_no_halt", hit, 0);
      async_reset("wrap_rst");
      fill_halt();
      mem[0] = 32'h0003_00AA;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      tick;
      chk("mid_decode_busy", bus.busy, 1);
      async_reset("mid_rst");
      repeat (6) begin
         tick;
         chk("post_rst_opcode", bus.opcode, NOP);
         chk("post_rst_rd_en", bus.mem_rd_en, 0);
         chk("post_rst_busy", bus.busy, 0);
      end
      for (int p = 0; p < 20; p++) begin
         for (int i = 0; i < 256; i++) mem[i] = gen_word();
         run_prog(30, 1'b1, 4'h0, hit);
         if (!hit) async_reset("rnd_rst");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
